// File: rtl/uart_pkg.sv
// Shared UART defaults: baud generator field widths and the standard 16x oversample ratio.
package uart_pkg;
    localparam int PS_W_DEF   = 4;
    localparam int DIV_W_DEF  = 8;
    localparam int FRAC_W_DEF = 4;
    localparam int OSR_W_DEF  = 4;
    localparam int OSR_16X    = 15;
endpackage

// File: rtl/uart_brg_dncntr.sv
// Load/decrement/hold down-counter with zero flag; clear beats load beats decrement.
// Latency: 1 clk from control to count; zero is combinational from the count.
module uart_brg_dncntr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic         dec,
    input  logic [W-1:0] ld_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (ld)
            cnt_d = ld_val;
        else if (dec)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/uart_brg_frac.sv
// Fractional baud rate generator: prescaler -> divider with fractional carry -> oversample counter.
// Latency: CE_16x/CE_1x are registered, one clk after the terminal count; En=0 freezes, Ld restarts.
module uart_brg_frac
    import uart_pkg::*;
#(
    parameter int PS_W   = PS_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR_W  = OSR_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              En,
    input  logic              Ld,
    input  logic [PS_W-1:0]   PS,
    input  logic [DIV_W-1:0]  Div,
    input  logic [FRAC_W-1:0] Frac,
    input  logic [OSR_W-1:0]  OSR,
    output logic              CE_16x,
    output logic              CE_1x
);
    logic              ps_zero, div_zero, os_zero;
    logic              tc_ps, tc_div;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W:0]    div_ld;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ce_16x_q, ce_16x_d;
    logic              ce_1x_q, ce_1x_d;

    // Ld gates the terminal counts so a restart cycle never emits a pulse.
    assign tc_ps  = En & ps_zero & ~Ld;
    assign tc_div = tc_ps & div_zero;

    // Divider is one bit wider so Div=all-ones plus a carry reloads 2^DIV_W.
    assign acc_sum = {1'b0, acc_q} + {1'b0, Frac};
    assign div_ld  = {1'b0, Div} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};

    uart_brg_dncntr #(.W(PS_W)) u_ps_cntr (
        .clk    (Clk),
        .rst_n  (Rst_N),
        .clr    (Ld),
        .ld     (tc_ps),
        .dec    (En),
        .ld_val (PS),
        .zero   (ps_zero)
    );

    uart_brg_dncntr #(.W(DIV_W + 1)) u_div_cntr (
        .clk    (Clk),
        .rst_n  (Rst_N),
        .clr    (Ld),
        .ld     (tc_div),
        .dec    (tc_ps),
        .ld_val (div_ld),
        .zero   (div_zero)
    );

    uart_brg_dncntr #(.W(OSR_W)) u_os_cntr (
        .clk    (Clk),
        .rst_n  (Rst_N),
        .clr    (Ld),
        .ld     (tc_div & os_zero),
        .dec    (tc_div),
        .ld_val (OSR),
        .zero   (os_zero)
    );

    always_comb begin
        acc_d    = acc_q;
        ce_16x_d = tc_div;
        ce_1x_d  = tc_div & os_zero;
        if (Ld)
            acc_d = '0;
        else if (tc_div)
            acc_d = acc_sum[FRAC_W-1:0];
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            acc_q    <= '0;
            ce_16x_q <= 1'b0;
            ce_1x_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            ce_16x_q <= ce_16x_d;
            ce_1x_q  <= ce_1x_d;
        end
    end

    assign CE_16x = ce_16x_q;
    assign CE_1x  = ce_1x_q;
endmodule

// File: tb/tb_uart_brg_frac.sv
// Directed bench for uart_brg_frac: pulse times are recorded per cycle and compared to hand-derived schedules.
module tb_uart_brg_frac;
    logic       Clk;
    logic       Rst_N;
    logic       En;
    logic       Ld;
    logic [3:0] PS;
    logic [7:0] Div;
    logic [3:0] Frac;
    logic [3:0] OSR;
    logic       CE_16x;
    logic       CE_1x;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t16[$];
    int t1[$];

    uart_brg_frac dut (
        .Clk    (Clk),
        .Rst_N  (Rst_N),
        .En     (En),
        .Ld     (Ld),
        .PS     (PS),
        .Div    (Div),
        .Frac   (Frac),
        .OSR    (OSR),
        .CE_16x (CE_16x),
        .CE_1x  (CE_1x)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic int at16(input int i);
        return (i < t16.size()) ? t16[i] : -1;
    endfunction

    function automatic int at1(input int i);
        return (i < t1.size()) ? t1[i] : -1;
    endfunction

    task automatic clear_capture();
        cyc = 0;
        t16.delete();
        t1.delete();
    endtask

    // Cycle k is the k-th rising edge after clear_capture; outputs sampled on the falling edge.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            cyc++;
            if (CE_16x === 1'b1) t16.push_back(cyc);
            if (CE_1x === 1'b1)  t1.push_back(cyc);
        end
    endtask

    task automatic restart(input logic [3:0] ps, input logic [7:0] div,
                           input logic [3:0] frac, input logic [3:0] osr);
        @(negedge Clk);
        PS = ps; Div = div; Frac = frac; OSR = osr;
        En = 1'b1;
        Ld = 1'b1;
        @(negedge Clk);
        Ld = 1'b0;
        clear_capture();
    endtask

    task automatic test_reset();
        Rst_N = 1'b1; En = 1'b0; Ld = 1'b0;
        PS = 4'd3; Div = 8'd9; Frac = 4'd0; OSR = 4'd15;
        #1 Rst_N = 1'b0;
        #1;
        n_checks++; if (CE_16x !== 1'b0) begin n_fail++; $display("FAIL reset_ce16: got %b want 0", CE_16x); end
        n_checks++; if (CE_1x !== 1'b0) begin n_fail++; $display("FAIL reset_ce1: got %b want 0", CE_1x); end
        repeat (2) @(negedge Clk);
        Rst_N = 1'b1;
        clear_capture();
        capture(4);
        n_checks++; if (t16.size() !== 0) begin n_fail++; $display("FAIL reset_en_off: got %0d pulses want 0", t16.size()); end
        En = 1'b1;
        capture(42);
        n_checks++; if (at16(0) !== 5) begin n_fail++; $display("FAIL startup_first16: got %0d want 5", at16(0)); end
        n_checks++; if (at1(0) !== 5) begin n_fail++; $display("FAIL startup_first1: got %0d want 5", at1(0)); end
        n_checks++; if (at16(1) !== 45) begin n_fail++; $display("FAIL startup_second16: got %0d want 45", at16(1)); end
    endtask

    task automatic test_continuous();
        restart(4'd0, 8'd0, 4'd0, 4'd15);
        capture(40);
        n_checks++; if (t16.size() !== 40) begin n_fail++; $display("FAIL cont_count16: got %0d want 40", t16.size()); end
        n_checks++; if (t1.size() !== 3) begin n_fail++; $display("FAIL cont_count1: got %0d want 3", t1.size()); end
        n_checks++; if (at1(0) !== 1) begin n_fail++; $display("FAIL cont_1x_0: got %0d want 1", at1(0)); end
        n_checks++; if (at1(1) !== 17) begin n_fail++; $display("FAIL cont_1x_1: got %0d want 17", at1(1)); end
        n_checks++; if (at1(2) !== 33) begin n_fail++; $display("FAIL cont_1x_2: got %0d want 33", at1(2)); end
    endtask

    task automatic test_divide();
        restart(4'd3, 8'd9, 4'd0, 4'd15);
        capture(1300);
        n_checks++; if (at16(1) !== 41) begin n_fail++; $display("FAIL div_period: got %0d want 41", at16(1)); end
        n_checks++; if (t16.size() !== 33) begin n_fail++; $display("FAIL div_count16: got %0d want 33", t16.size()); end
        n_checks++; if (at16(32) !== 1281) begin n_fail++; $display("FAIL div_last16: got %0d want 1281", at16(32)); end
        n_checks++; if (t1.size() !== 3) begin n_fail++; $display("FAIL div_count1: got %0d want 3", t1.size()); end
        n_checks++; if (at1(1) !== 641) begin n_fail++; $display("FAIL div_1x_1: got %0d want 641", at1(1)); end
        n_checks++; if (at1(2) !== 1281) begin n_fail++; $display("FAIL div_1x_2: got %0d want 1281", at1(2)); end
    endtask

    task automatic test_fractional();
        restart(4'd0, 8'd4, 4'd8, 4'd15);
        capture(176);
        n_checks++; if (t16.size() !== 32) begin n_fail++; $display("FAIL frac_count: got %0d want 32", t16.size()); end
        n_checks++; if (at16(1) !== 6) begin n_fail++; $display("FAIL frac_gap5: got %0d want 6", at16(1)); end
        n_checks++; if (at16(2) !== 12) begin n_fail++; $display("FAIL frac_gap6: got %0d want 12", at16(2)); end
        n_checks++; if (at16(31) !== 171) begin n_fail++; $display("FAIL frac_last: got %0d want 171", at16(31)); end
        n_checks++; if (at1(1) !== 89) begin n_fail++; $display("FAIL frac_1x: got %0d want 89", at1(1)); end
    endtask

    task automatic test_enable_freeze();
        restart(4'd3, 8'd9, 4'd0, 4'd15);
        capture(20);
        En = 1'b0;
        capture(7);
        n_checks++; if (t16.size() !== 1) begin n_fail++; $display("FAIL freeze_quiet: got %0d pulses want 1", t16.size()); end
        En = 1'b1;
        capture(673);
        n_checks++; if (at16(1) !== 48) begin n_fail++; $display("FAIL freeze_shift1: got %0d want 48", at16(1)); end
        n_checks++; if (at16(2) !== 88) begin n_fail++; $display("FAIL freeze_shift2: got %0d want 88", at16(2)); end
        n_checks++; if (t16.size() !== 18) begin n_fail++; $display("FAIL freeze_count: got %0d want 18", t16.size()); end
        n_checks++; if (at1(1) !== 648) begin n_fail++; $display("FAIL freeze_1x: got %0d want 648", at1(1)); end
    endtask

    task automatic test_reload_point();
        restart(4'd3, 8'd9, 4'd0, 4'd15);
        capture(10);
        Div = 8'd4;
        capture(60);
        n_checks++; if (at16(1) !== 41) begin n_fail++; $display("FAIL reload_defer: got %0d want 41", at16(1)); end
        n_checks++; if (at16(2) !== 61) begin n_fail++; $display("FAIL reload_new: got %0d want 61", at16(2)); end
    endtask

    task automatic test_ld_restart();
        restart(4'd0, 8'd0, 4'd0, 4'd15);
        capture(2);
        Ld = 1'b1;
        @(negedge Clk);
        n_checks++; if (CE_16x !== 1'b0) begin n_fail++; $display("FAIL ld_quiet: got %b want 0", CE_16x); end
        Ld = 1'b0;
        clear_capture();
        capture(1);
        n_checks++; if (at1(0) !== 1) begin n_fail++; $display("FAIL ld_os_clear: got %0d want 1", at1(0)); end

        restart(4'd3, 8'd9, 4'd0, 4'd15);
        capture(15);
        Div = 8'd4;
        Ld  = 1'b1;
        @(negedge Clk);
        Ld = 1'b0;
        clear_capture();
        capture(50);
        n_checks++; if (at16(0) !== 1) begin n_fail++; $display("FAIL ld_first: got %0d want 1", at16(0)); end
        n_checks++; if (at16(1) !== 21) begin n_fail++; $display("FAIL ld_period1: got %0d want 21", at16(1)); end
        n_checks++; if (at16(2) !== 41) begin n_fail++; $display("FAIL ld_period2: got %0d want 41", at16(2)); end
    endtask

    task automatic test_async_reset();
        // Continues the PS=3, Div=4 schedule; cycle 61 carries a pulse.
        capture(11);
        n_checks++; if (CE_16x !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b want 1", CE_16x); end
        #2 Rst_N = 1'b0;
        #1;
        n_checks++; if (CE_16x !== 1'b0) begin n_fail++; $display("FAIL arst_async: got %b want 0", CE_16x); end
        @(negedge Clk);
        Rst_N = 1'b1;
        clear_capture();
        capture(30);
        n_checks++; if (at16(0) !== 1) begin n_fail++; $display("FAIL arst_first: got %0d want 1", at16(0)); end
        n_checks++; if (at16(1) !== 21) begin n_fail++; $display("FAIL arst_period: got %0d want 21", at16(1)); end
    endtask

    task automatic test_max_values();
        restart(4'd15, 8'd255, 4'd15, 4'd15);
        capture(8210);
        n_checks++; if (at16(1) !== 4097) begin n_fail++; $display("FAIL max_short: got %0d want 4097", at16(1)); end
        n_checks++; if (at16(2) !== 8209) begin n_fail++; $display("FAIL max_long: got %0d want 8209", at16(2)); end
        n_checks++; if (t16.size() !== 3) begin n_fail++; $display("FAIL max_count: got %0d want 3", t16.size()); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_divide();
        test_fractional();
        test_enable_freeze();
        test_reload_point();
        test_ld_restart();
        test_async_reset();
        test_max_values();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
